// File: rtl/capture_pack_ctrl.sv
// capture_pack_ctrl
//   Packs one binarized CCD frame into 32-bit words for the SDRAM write FIFO.
//   A rising edge on iSTART arms the capture. Packing starts at the next
//   frame boundary (iFVAL rising edge). Each valid pixel fills the next bit of
//   the word, starting at bit 0. Every full word is presented split across two
//   16-bit write ports with a single-cycle strobe. A frame that ends early
//   flushes its partial word, with the unfilled bits set to zero.
//
// Ports
//   CCD_PIXCLK  in   pixel clock, all logic on rising edge
//   DLY_RST_1   in   asynchronous active-low reset
//   iSTART      in   capture request level from HPS
//   iFVAL       in   registered frame valid
//   iDVAL       in   binarized pixel valid
//   iPIX        in   binarized pixel bit
//   iFIFO_FULL  in   write FIFO full flag (monitored only)
//   oWR_LO      out  packed word [15:0]
//   oWR_HI      out  packed word [31:16]
//   oWR         out  one-cycle write strobe
//   oWORD_CNT   out  words written this frame (saturating)
//   oBUSY       out  armed or capturing
//   oDONE       out  frame complete, held until iSTART drops
//   oSHORT      out  frame ended before WORDS_PER_FRAME words
//   oOVERRUN    out  sticky: write issued while FIFO was full
module capture_pack_ctrl #(
    parameter int unsigned WORDS_PER_FRAME = 9600
) (
    input  logic        CCD_PIXCLK,
    input  logic        DLY_RST_1,
    input  logic        iSTART,
    input  logic        iFVAL,
    input  logic        iDVAL,
    input  logic        iPIX,
    input  logic        iFIFO_FULL,
    output logic [15:0] oWR_LO,
    output logic [15:0] oWR_HI,
    output logic        oWR,
    output logic [13:0] oWORD_CNT,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oSHORT,
    output logic        oOVERRUN
);

    localparam logic [13:0] WPF = 14'(WORDS_PER_FRAME);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    // Holds "iSTART was low last cycle". Its reset value of 0 treats iSTART as
    // already high. A request held high across reset therefore does not re-arm;
    // iSTART must drop and rise again.
    logic        start_lo_q, start_lo_d;
    logic        fval_q;
    logic [4:0]  bit_q, bit_d;
    logic [31:0] sh_q, sh_d;
    logic [15:0] lo_q, lo_d, hi_q, hi_d;
    logic        wr_q, wr_d;
    logic [13:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        short_q, short_d;
    logic        ovr_q, ovr_d;

    logic [31:0] word_w;
    logic        full_word;
    logic        start_rise, fval_rise, fval_fall;

    assign start_rise = iSTART & start_lo_q;
    assign fval_rise  = iFVAL & ~fval_q;
    assign fval_fall  = ~iFVAL & fval_q;

    always_comb begin
        state_d    = state_q;
        start_lo_d = ~iSTART;
        bit_d      = bit_q;
        sh_d       = sh_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        wr_d       = 1'b0;
        cnt_d      = cnt_q;
        done_d     = done_q;
        short_d    = short_q;
        ovr_d      = ovr_q | (wr_q & iFIFO_FULL);
        word_w     = sh_q;
        full_word  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = '0;
                    short_d = 1'b0;
                    ovr_d   = 1'b0;
                end
            end

            S_ARM: begin
                if (!iSTART)        state_d = S_IDLE;
                else if (fval_rise) state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                if (!iSTART) begin
                    state_d = S_IDLE;
                end else begin
                    if (iDVAL) begin
                        word_w[bit_q] = iPIX;
                        bit_d         = bit_q + 5'd1;
                        sh_d          = word_w;
                    end
                    full_word = iDVAL && (bit_q == 5'd31);
                    if (full_word) begin
                        lo_d = word_w[15:0];
                        hi_d = word_w[31:16];
                        wr_d = 1'b1;
                        sh_d = '0;
                        if (cnt_q < WPF) cnt_d = cnt_q + 14'd1;
                    end
                    // A frame end on the same cycle as the 32nd pixel leaves
                    // bit_d at 0. That case goes straight to DONE, so no
                    // padding word is written.
                    if ((full_word && (cnt_d >= WPF)) || (fval_fall && (bit_d == 5'd0))) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        short_d = (cnt_d < WPF);
                    end else if (fval_fall) begin
                        state_d = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                if (!iSTART) begin
                    state_d = S_IDLE;
                end else begin
                    lo_d    = sh_q[15:0];
                    hi_d    = sh_q[31:16];
                    wr_d    = 1'b1;
                    sh_d    = '0;
                    bit_d   = '0;
                    if (cnt_q < WPF) cnt_d = cnt_q + 14'd1;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    short_d = (cnt_d < WPF);
                end
            end

            S_DONE: begin
                if (!iSTART) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CCD_PIXCLK or negedge DLY_RST_1) begin
        if (!DLY_RST_1) begin
            state_q    <= S_IDLE;
            start_lo_q <= 1'b0;
            fval_q     <= 1'b0;
            bit_q      <= '0;
            sh_q       <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_lo_q <= start_lo_d;
            fval_q     <= iFVAL;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            short_q    <= short_d;
            ovr_q      <= ovr_d;
        end
    end

    assign oWR_LO    = lo_q;
    assign oWR_HI    = hi_q;
    assign oWR       = wr_q;
    assign oWORD_CNT = cnt_q;
    assign oBUSY     = (state_q == S_ARM) || (state_q == S_CAPTURE);
    assign oDONE     = done_q;
    assign oSHORT    = short_q;
    assign oOVERRUN  = ovr_q;

endmodule

// File: tb/tb_capture_pack_ctrl.sv
module tb_capture_pack_ctrl;

    logic clk, rst_n, start, fval, dval, pix, full;

    logic [15:0] lo4, hi4, loD, hiD;
    logic        wr4, wrD, busy4, busyD, done4, doneD, short4, shortD, ovr4, ovrD;
    logic [13:0] cnt4, cntD;

    capture_pack_ctrl #(.WORDS_PER_FRAME(4)) dut4 (
        .CCD_PIXCLK(clk), .DLY_RST_1(rst_n), .iSTART(start), .iFVAL(fval),
        .iDVAL(dval), .iPIX(pix), .iFIFO_FULL(full),
        .oWR_LO(lo4), .oWR_HI(hi4), .oWR(wr4), .oWORD_CNT(cnt4),
        .oBUSY(busy4), .oDONE(done4), .oSHORT(short4), .oOVERRUN(ovr4)
    );

    capture_pack_ctrl dutD (
        .CCD_PIXCLK(clk), .DLY_RST_1(rst_n), .iSTART(start), .iFVAL(fval),
        .iDVAL(dval), .iPIX(pix), .iFIFO_FULL(full),
        .oWR_LO(loD), .oWR_HI(hiD), .oWR(wrD), .oWORD_CNT(cntD),
        .oBUSY(busyD), .oDONE(doneD), .oSHORT(shortD), .oOVERRUN(ovrD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Words written by each instance, captured on the falling edge.
    logic [31:0] q4[$];
    logic [31:0] qD[$];

    initial begin
        forever begin
            @(negedge clk);
            if (wr4) q4.push_back({hi4, lo4});
            if (wrD) qD.push_back({hiD, loD});
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic b);
        dval = 1'b1;
        pix  = b;
        tick();
        dval = 1'b0;
        pix  = 1'b0;
    endtask

    task automatic go_idle();
        start = 1'b0;
        fval  = 1'b0;
        dval  = 1'b0;
        full  = 1'b0;
        repeat (3) tick();
        q4.delete();
        qD.delete();
    endtask

    logic [31:0] pat;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fval  = 1'b0;
        dval  = 1'b0;
        pix   = 1'b0;
        full  = 1'b0;
        pat   = 32'h1234_5678;
        #12;
        check("rst_wr",    {31'd0, wrD}, 32'd0);
        check("rst_data",  {hiD, loD}, 32'd0);
        check("rst_cnt",   {18'd0, cntD}, 32'd0);
        check("rst_flags", {28'd0, busyD, doneD, shortD, ovrD}, 32'd0);
        check("rst_flags4", {28'd0, busy4, done4, short4, ovr4}, 32'd0);
        tick();
        rst_n = 1'b1;
        go_idle();

        // 128 alternating pixels into a 4-word frame
        start = 1'b1; tick();
        fval = 1'b1; tick();
        check("A_busy", {31'd0, busy4}, 32'd1);
        for (int unsigned i = 0; i < 128; i++) px(1'(i & 1));
        tick();
        check("A_nwr", q4.size(), 32'd4);
        for (int unsigned i = 0; i < 4; i++) check("A_word", q4[i], 32'hAAAA_AAAA);
        check("A_cnt",   {18'd0, cnt4}, 32'd4);
        check("A_done",  {31'd0, done4}, 32'd1);
        check("A_short", {31'd0, short4}, 32'd0);
        for (int unsigned i = 0; i < 32; i++) px(1'b1);
        tick();
        check("A_ignored", q4.size(), 32'd4);
        check("A_cntsat", {18'd0, cnt4}, 32'd4);
        go_idle();
        check("A_done_clr", {31'd0, done4}, 32'd0);

        // 40 pixels of 1 then frame end: full word plus flushed partial word
        start = 1'b1; tick();
        fval = 1'b1; tick();
        check("B_busy", {31'd0, busyD}, 32'd1);
        for (int unsigned i = 0; i < 40; i++) px(1'b1);
        fval = 1'b0;
        repeat (3) tick();
        check("B_nwr",   qD.size(), 32'd2);
        check("B_w0",    qD[0], 32'hFFFF_FFFF);
        check("B_w1",    qD[1], 32'h0000_00FF);
        check("B_cnt",   {18'd0, cntD}, 32'd2);
        check("B_short", {31'd0, shortD}, 32'd1);
        check("B_done",  {31'd0, doneD}, 32'd1);
        repeat (4) tick();
        check("B_done_hold", {31'd0, doneD}, 32'd1);
        start = 1'b0; tick();
        check("B_done_drop", {31'd0, doneD}, 32'd0);
        check("B_idle", {31'd0, busyD}, 32'd0);
        go_idle();

        // Arm in the middle of a frame: wait for the next frame start
        fval = 1'b1; repeat (2) tick();
        start = 1'b1; tick();
        for (int unsigned i = 0; i < 10; i++) px(1'b1);
        check("C_armwait", {31'd0, busyD}, 32'd1);
        check("C_nowr", qD.size(), 32'd0);
        fval = 1'b0; repeat (2) tick();
        fval = 1'b1; tick();
        for (int unsigned i = 0; i < 32; i++) px(pat[i]);
        tick();
        check("C_nwr", qD.size(), 32'd1);
        check("C_word", qD[0], 32'h1234_5678);
        go_idle();

        // Overrun flag on a write issued while the FIFO is full
        start = 1'b1; tick();
        fval = 1'b1; tick();
        for (int unsigned i = 0; i < 32; i++) px(1'b0);
        tick();
        check("D_ovr_clean", {31'd0, ovrD}, 32'd0);
        for (int unsigned i = 0; i < 32; i++) px(1'b0);
        check("D_wr", {31'd0, wrD}, 32'd1);
        full = 1'b1; tick();
        full = 1'b0;
        check("D_ovr", {31'd0, ovrD}, 32'd1);
        check("D_cnt", {18'd0, cntD}, 32'd2);
        check("D_nwr", qD.size(), 32'd2);
        fval = 1'b0; repeat (2) tick();
        check("D_done", {31'd0, doneD}, 32'd1);
        check("D_ovr_done", {31'd0, ovrD}, 32'd1);
        start = 1'b0; tick();
        check("D_ovr_idle", {31'd0, ovrD}, 32'd1);
        start = 1'b1; tick();
        check("D_ovr_clr", {31'd0, ovrD}, 32'd0);
        check("D_cnt_clr", {18'd0, cntD}, 32'd0);
        qD.delete();

        // Abort by dropping iSTART mid-capture
        fval = 1'b1; tick();
        for (int unsigned i = 0; i < 52; i++) px(1'b1);
        start = 1'b0; tick();
        check("E_busy", {31'd0, busyD}, 32'd0);
        check("E_done", {31'd0, doneD}, 32'd0);
        for (int unsigned i = 0; i < 20; i++) px(1'b1);
        tick();
        check("E_nwr", qD.size(), 32'd1);
        check("E_cnt", {18'd0, cntD}, 32'd1);

        // Asynchronous reset mid-capture
        fval = 1'b0; tick();
        start = 1'b1; tick();
        fval = 1'b1; tick();
        for (int unsigned i = 0; i < 40; i++) px(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("R_data", {hiD, loD}, 32'd0);
        check("R_cnt", {18'd0, cntD}, 32'd0);
        check("R_flags", {27'd0, wrD, busyD, doneD, shortD, ovrD}, 32'd0);
        qD.delete();
        tick();
        rst_n = 1'b1;
        for (int unsigned i = 0; i < 40; i++) px(1'b1);
        tick();
        check("R_nowr", qD.size(), 32'd0);
        check("R_noarm", {31'd0, busyD}, 32'd1 - 32'd1);
        start = 1'b0; tick();
        start = 1'b1; tick();
        check("R_rearm", {31'd0, busyD}, 32'd1);

        // 32nd pixel on the same cycle as the frame end
        fval = 1'b0; tick();
        fval = 1'b1; tick();
        qD.delete();
        for (int unsigned i = 0; i < 31; i++) px(1'b1);
        dval = 1'b1; pix = 1'b1; fval = 1'b0;
        tick();
        dval = 1'b0; pix = 1'b0;
        repeat (3) tick();
        check("F_nwr",   qD.size(), 32'd1);
        check("F_word",  qD[0], 32'hFFFF_FFFF);
        check("F_cnt",   {18'd0, cntD}, 32'd1);
        check("F_done",  {31'd0, doneD}, 32'd1);
        check("F_short", {31'd0, shortD}, 32'd1);
        go_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
